find_string_key_cond: RTL and testbench
=======================================

# find_string_key_cond

Input conditioning stage placed directly upstream of the string-search core. It synchronises and debounces the active-low push buttons `submit_n`, `delete_n` and `roll_back_n`, and the `done` slide switch. Each accepted button press becomes exactly one single-cycle pulse; `done` becomes a clean level. On every accepted `submit` press it also latches the 4-bit `in_str` switches, so the core receives a glitch-free nibble together with its strobe.

## Interface
Parameters:
- `FREQUENCY`, 50_000_000, clk frequency in Hz.
- `DEBOUNCE_MS`, 20, stability window; DB = max(1, FREQUENCY*DEBOUNCE_MS/1000) cycles.
- `REPEAT_DELAY_MS`, 500, autorepeat first delay; RD = max(1, FREQUENCY*REPEAT_DELAY_MS/1000).
- `REPEAT_RATE_MS`, 100, autorepeat period; RR = max(1, FREQUENCY*REPEAT_RATE_MS/1000).

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `submit_n` in 1: raw button, 0 = pressed.
- `delete_n` in 1: raw button, 0 = pressed.
- `roll_back_n` in 1: raw button, 0 = pressed.
- `done` in 1: raw switch level.
- `in_str` in 4: raw data switches.
- `submit_p` out 1: one-cycle accepted submit.
- `delete_p` out 1: one-cycle accepted delete.
- `roll_back_p` out 1: one-cycle accepted roll-back.
- `done_lvl` out 1: debounced `done`.
- `nibble_out` out 4: `in_str` latched on `submit_p`.

## Operation
- All raw inputs, including `in_str`, pass through a 2-FF synchroniser.
- Synchroniser reset values: 1 for buttons, 0 for `done` and `in_str`.
- Per-button FSM, with one DB-range counter per button:
  - RELEASED: synced input = 0 → PRESS_WAIT, counter cleared.
  - PRESS_WAIT: input returns to 1 → RELEASED; input held 0 for DB consecutive cycles → HELD and a pulse is requested.
  - HELD: input = 1 → RELEASE_WAIT, counter cleared.
  - RELEASE_WAIT: input returns to 0 → HELD (no pulse); input held 1 for DB consecutive cycles → RELEASED.
- `done` uses the same counter scheme as a level filter. `done_lvl` changes only after the new value has been stable for DB cycles. It produces no pulse.
- Arbitration: when several pulse requests fall in the same cycle, priority is `roll_back` > `delete` > `submit`.
  - Losing requests are dropped, not queued.
  - Their FSMs still enter HELD, so the press is consumed.
- `nibble_out` loads the synced `in_str` on the same edge that asserts `submit_p`; otherwise it holds.
- Counters saturate and never wrap.

## Timing
- Reset values: all pulses 0, `done_lvl` 0, `nibble_out` 4'b0000, all FSMs in RELEASED, counters 0.
- Press latency: raw input sampled low at edge k gives the pulse high during the cycle after edge k+1+DB, i.e. 2+DB cycles after the raw edge.
- Release latency: 2+DB cycles. A new press is accepted only from RELEASED.
- Pulse width: exactly one cycle. At most one of the three pulses is high in any cycle.
- Bounces shorter than DB cycles produce no pulse and no `done_lvl` change.
- Reset mid-operation:
  - Outputs clear immediately, whatever the FSM state.
  - A button still held when reset deasserts is seen as a fresh press, because the synchroniser resets to 1.
  - That press pulses 2+DB cycles after reset deasserts.

## Configuration
- `KEY_AUTOREPEAT_EN` defined:
  - While `delete` stays in HELD, a further `delete_p` request fires RD cycles after the initial pulse, then every RR cycles.
  - Repeat requests follow the normal arbitration.
  - Repeating stops on entry to RELEASE_WAIT.
- `KEY_AUTOREPEAT_EN` undefined: the repeat counter logic is absent, and one press gives exactly one `delete_p`.
- `submit` and `roll_back` never autorepeat in either build.

## Test plan
Common setup: FREQUENCY=100, DEBOUNCE_MS=20, REPEAT_DELAY_MS=500, REPEAT_RATE_MS=100, giving DB=2, RD=50, RR=10. t=0 is the raw edge.
1. Clean press: `in_str`=4'b0011, `submit_n` low for 8 cycles → a single `submit_p` at cycle 4 with `nibble_out`=4'b0011, and no other pulse.
2. Bounce: `submit_n` toggles each cycle for 7 cycles, then is held high → no `submit_p`, and `nibble_out` is unchanged.
3. Autorepeat: `delete_n` held low for 80 cycles.
   - With `KEY_AUTOREPEAT_EN`: `delete_p` at cycles 4, 54, 64, 74.
   - Without it: `delete_p` only at cycle 4.
4. Simultaneous press: `submit_n` and `delete_n` fall on the same edge → only `delete_p` at cycle 4. No `submit_p` until `submit_n` is released and pressed again.
5. Reset during hold: `roll_back_n` is held low, reset is asserted for 3 cycles at cycle 6, then the button stays held.
   - Outputs are 0 during reset.
   - `roll_back_p` fires once, 4 cycles after reset deasserts.
6. `done` filter: a 1-cycle high glitch on `done` → `done_lvl` stays 0. A sustained high → `done_lvl` = 1 at cycle 4 and stays there.

Source files
------------

// File: rtl/find_string_key_cond.sv
// find_string_key_cond
//   Conditions the raw push buttons (submit_n, delete_n, roll_back_n) and the
//   done switch for the string-search core. Buttons become single-cycle
//   pulses (priority roll_back > delete > submit), done becomes a debounced
//   level, and in_str is latched alongside every accepted submit pulse.
//   Optional build macro: KEY_AUTOREPEAT_EN adds delete autorepeat.
//
//   state        | meaning
//   RELEASED     | button idle, a new press may be accepted
//   PRESS_WAIT   | input low, counting towards the debounce window
//   HELD         | press accepted, waiting for the button to let go
//   RELEASE_WAIT | input high, counting towards the debounce window
module find_string_key_cond #(
    parameter int FREQUENCY       = 50_000_000,
    parameter int DEBOUNCE_MS     = 20,
    parameter int REPEAT_DELAY_MS = 500,
    parameter int REPEAT_RATE_MS  = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       submit_n,
    input  logic       delete_n,
    input  logic       roll_back_n,
    input  logic       done,
    input  logic [3:0] in_str,
    output logic       submit_p,
    output logic       delete_p,
    output logic       roll_back_p,
    output logic       done_lvl,
    output logic [3:0] nibble_out
);

    // 64-bit intermediates: FREQUENCY * ms overflows 32 bits at default settings
    localparam longint DB_L = longint'(FREQUENCY) * longint'(DEBOUNCE_MS) / 1000;
    localparam int     DB   = (DB_L < 1) ? 1 : int'(DB_L);
    localparam int     CW   = $clog2(DB + 1);

    typedef enum logic [1:0] {RELEASED, PRESS_WAIT, HELD, RELEASE_WAIT} key_state_t;

    // index 0 = submit, 1 = delete, 2 = roll_back
    logic [2:0]    btn_s1, btn_s2;
    logic          done_s1, done_s2;
    logic [3:0]    str_s1, str_s2;
    key_state_t    key_state [3];
    logic [CW-1:0] key_cnt [3];
    logic [2:0]    cnt_last;
    logic [2:0]    press_req;
    logic [CW-1:0] done_cnt;
    logic          req_sub, req_del, req_rb;
    logic          win_sub, win_del;

    // Two-flop synchronisers; buttons reset to released so a held key reads as a new press
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_s1  <= 3'b111;
            btn_s2  <= 3'b111;
            done_s1 <= 1'b0;
            done_s2 <= 1'b0;
            str_s1  <= 4'b0000;
            str_s2  <= 4'b0000;
        end else begin
            btn_s1  <= {roll_back_n, delete_n, submit_n};
            btn_s2  <= btn_s1;
            done_s1 <= done;
            done_s2 <= done_s1;
            str_s1  <= in_str;
            str_s2  <= str_s1;
        end
    end

    // Press requests: the DB-th consecutive low sample (the RELEASED sample counts as the first)
    always_comb begin
        cnt_last  = '0;
        press_req = '0;
        for (int i = 0; i < 3; i++) begin
            cnt_last[i] = (int'(key_cnt[i]) + 2 >= DB);
            if (!btn_s2[i]) begin
                if (key_state[i] == RELEASED && DB == 1)
                    press_req[i] = 1'b1;
                else if (key_state[i] == PRESS_WAIT && cnt_last[i])
                    press_req[i] = 1'b1;
            end
        end
    end

    // Per-button debounce FSMs with saturating window counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                key_state[i] <= RELEASED;
                key_cnt[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                case (key_state[i])
                    RELEASED: begin
                        if (!btn_s2[i]) begin
                            key_state[i] <= (DB == 1) ? HELD : PRESS_WAIT;
                            key_cnt[i]   <= '0;
                        end
                    end
                    PRESS_WAIT: begin
                        if (btn_s2[i]) begin
                            key_state[i] <= RELEASED;
                            key_cnt[i]   <= '0;
                        end else if (cnt_last[i]) begin
                            key_state[i] <= HELD;
                            key_cnt[i]   <= '0;
                        end else if (key_cnt[i] != '1) begin
                            key_cnt[i] <= key_cnt[i] + 1'b1;
                        end
                    end
                    HELD: begin
                        if (btn_s2[i]) begin
                            key_state[i] <= (DB == 1) ? RELEASED : RELEASE_WAIT;
                            key_cnt[i]   <= '0;
                        end
                    end
                    RELEASE_WAIT: begin
                        if (!btn_s2[i]) begin
                            key_state[i] <= HELD;
                            key_cnt[i]   <= '0;
                        end else if (cnt_last[i]) begin
                            key_state[i] <= RELEASED;
                            key_cnt[i]   <= '0;
                        end else if (key_cnt[i] != '1) begin
                            key_cnt[i] <= key_cnt[i] + 1'b1;
                        end
                    end
                    default: begin
                        key_state[i] <= RELEASED;
                        key_cnt[i]   <= '0;
                    end
                endcase
            end
        end
    end

    assign req_sub = press_req[0];
    assign req_rb  = press_req[2];

`ifdef KEY_AUTOREPEAT_EN
    localparam longint RD_L = longint'(FREQUENCY) * longint'(REPEAT_DELAY_MS) / 1000;
    localparam longint RR_L = longint'(FREQUENCY) * longint'(REPEAT_RATE_MS) / 1000;
    localparam int     RD   = (RD_L < 1) ? 1 : int'(RD_L);
    localparam int     RR   = (RR_L < 1) ? 1 : int'(RR_L);
    localparam int     RW   = $clog2(((RD > RR) ? RD : RR) + 1);

    logic [RW-1:0] rep_cnt;
    logic          rep_req;

    assign rep_req = (key_state[1] == HELD) && !btn_s2[1] && (rep_cnt == '0);
    assign req_del = press_req[1] | rep_req;

    // Repeat down-counter: preloaded with the first delay outside HELD, reloads with the rate at terminal count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rep_cnt <= RW'(RD - 1);
        end else if (key_state[1] != HELD) begin
            rep_cnt <= RW'(RD - 1);
        end else if (!btn_s2[1]) begin
            if (rep_cnt == '0)
                rep_cnt <= RW'(RR - 1);
            else
                rep_cnt <= rep_cnt - 1'b1;
        end
    end
`else
    assign req_del = press_req[1];
`endif

    // Fixed priority: losing requests are simply dropped
    assign win_del = req_del & ~req_rb;
    assign win_sub = req_sub & ~req_del & ~req_rb;

    // Registered pulses and the nibble captured with the submit strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            roll_back_p <= 1'b0;
            delete_p    <= 1'b0;
            submit_p    <= 1'b0;
            nibble_out  <= 4'b0000;
        end else begin
            roll_back_p <= req_rb;
            delete_p    <= win_del;
            submit_p    <= win_sub;
            if (win_sub)
                nibble_out <= str_s2;
        end
    end

    // done level filter: follows the synced input only after DB stable samples
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_lvl <= 1'b0;
            done_cnt <= '0;
        end else if (done_s2 != done_lvl) begin
            if (int'(done_cnt) + 1 >= DB) begin
                done_lvl <= done_s2;
                done_cnt <= '0;
            end else begin
                done_cnt <= done_cnt + 1'b1;
            end
        end else begin
            done_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_find_string_key_cond.sv
// Directed bench for find_string_key_cond with DB=2, RD=50, RR=10.
// Cycle c means "just after rising edge c"; raw inputs change at cycle 0.
module tb_find_string_key_cond;

    logic       clk = 1'b0;
    logic       reset;
    logic       submit_n, delete_n, roll_back_n, done;
    logic [3:0] in_str;
    logic       submit_p, delete_p, roll_back_p, done_lvl;
    logic [3:0] nibble_out;

    int n_cmp  = 0;
    int n_bad  = 0;
    int n_multi = 0;
    int sub_q[$];
    int del_q[$];
    int rb_q[$];
    logic [3:0] nib_at_sub;
    int glitch_seen;
    int first_hi;

    find_string_key_cond #(
        .FREQUENCY(100),
        .DEBOUNCE_MS(20),
        .REPEAT_DELAY_MS(500),
        .REPEAT_RATE_MS(100)
    ) dut (
        .clk(clk),
        .reset(reset),
        .submit_n(submit_n),
        .delete_n(delete_n),
        .roll_back_n(roll_back_n),
        .done(done),
        .in_str(in_str),
        .submit_p(submit_p),
        .delete_p(delete_p),
        .roll_back_p(roll_back_p),
        .done_lvl(done_lvl),
        .nibble_out(nibble_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int q_at(input int q[$], input int idx);
        if (idx < q.size())
            return q[idx];
        return -1;
    endfunction

    task automatic clear_q();
        sub_q.delete();
        del_q.delete();
        rb_q.delete();
    endtask

    task automatic step(input int c);
        @(posedge clk);
        #1;
        if (submit_p === 1'b1) begin
            sub_q.push_back(c);
            nib_at_sub = nibble_out;
        end
        if (delete_p === 1'b1)
            del_q.push_back(c);
        if (roll_back_p === 1'b1)
            rb_q.push_back(c);
        if ($countones({submit_p, delete_p, roll_back_p}) > 1)
            n_multi++;
    endtask

    initial begin
        reset       = 1'b1;
        submit_n    = 1'b1;
        delete_n    = 1'b1;
        roll_back_n = 1'b1;
        done        = 1'b0;
        in_str      = 4'b0000;
        nib_at_sub  = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_submit_p", 32'(submit_p), 0);
        check_eq("rst_delete_p", 32'(delete_p), 0);
        check_eq("rst_roll_back_p", 32'(roll_back_p), 0);
        check_eq("rst_done_lvl", 32'(done_lvl), 0);
        check_eq("rst_nibble", 32'(nibble_out), 0);
        reset = 1'b0;
        clear_q();
        for (int c = 1; c <= 6; c++) step(c);
        check_eq("idle_no_pulse", 32'(sub_q.size() + del_q.size() + rb_q.size()), 0);

        // 1: clean submit press with in_str = 0011
        in_str = 4'b0011;
        for (int c = 1; c <= 4; c++) step(c);
        clear_q();
        submit_n = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            step(c);
            if (c == 8) submit_n = 1'b1;
        end
        check_eq("clean_sub_count", 32'(sub_q.size()), 1);
        check_eq("clean_sub_cycle", 32'(q_at(sub_q, 0)), 4);
        check_eq("clean_nibble_at_pulse", 32'(nib_at_sub), 32'h3);
        check_eq("clean_other_pulses", 32'(del_q.size() + rb_q.size()), 0);

        // 2: bouncing submit, nibble must keep 0011
        in_str = 4'b1010;
        for (int c = 1; c <= 4; c++) step(c);
        clear_q();
        submit_n = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            step(c);
            submit_n = (c <= 6) ? ((c % 2) == 1) : 1'b1;
        end
        check_eq("bounce_sub_count", 32'(sub_q.size()), 0);
        check_eq("bounce_nibble_hold", 32'(nibble_out), 32'h3);

        // 3: delete held for 80 cycles
        clear_q();
        delete_n = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            step(c);
            if (c == 80) delete_n = 1'b1;
        end
`ifdef KEY_AUTOREPEAT_EN
        check_eq("rep_del_count", 32'(del_q.size()), 4);
        check_eq("rep_del_0", 32'(q_at(del_q, 0)), 4);
        check_eq("rep_del_1", 32'(q_at(del_q, 1)), 54);
        check_eq("rep_del_2", 32'(q_at(del_q, 2)), 64);
        check_eq("rep_del_3", 32'(q_at(del_q, 3)), 74);
`else
        check_eq("rep_del_count", 32'(del_q.size()), 1);
        check_eq("rep_del_0", 32'(q_at(del_q, 0)), 4);
`endif
        check_eq("rep_no_sub", 32'(sub_q.size()), 0);

        // 4: submit and delete together, then a second submit press
        clear_q();
        submit_n = 1'b0;
        delete_n = 1'b0;
        for (int c = 1; c <= 45; c++) begin
            step(c);
            if (c == 8) begin
                submit_n = 1'b1;
                delete_n = 1'b1;
            end
            if (c == 20) submit_n = 1'b0;
            if (c == 28) submit_n = 1'b1;
        end
        check_eq("simul_del_count", 32'(del_q.size()), 1);
        check_eq("simul_del_cycle", 32'(q_at(del_q, 0)), 4);
        check_eq("simul_sub_count", 32'(sub_q.size()), 1);
        check_eq("simul_sub_cycle", 32'(q_at(sub_q, 0)), 24);
        check_eq("simul_nibble", 32'(nib_at_sub), 32'hA);

        // 5: reset while roll_back is held
        clear_q();
        roll_back_n = 1'b0;
        for (int c = 1; c <= 35; c++) begin
            step(c);
            if (c == 7 || c == 9) begin
                check_eq("rst_hold_rb_p", 32'(roll_back_p), 0);
                check_eq("rst_hold_nibble", 32'(nibble_out), 0);
            end
            if (c == 6) reset = 1'b1;
            if (c == 9) reset = 1'b0;
            if (c == 25) roll_back_n = 1'b1;
        end
        check_eq("rst_hold_rb_count", 32'(rb_q.size()), 2);
        check_eq("rst_hold_rb_first", 32'(q_at(rb_q, 0)), 4);
        check_eq("rst_hold_rb_again", 32'(q_at(rb_q, 1)), 13);
        check_eq("rst_hold_nibble_after", 32'(nibble_out), 0);

        // 6: done glitch, then sustained high
        clear_q();
        glitch_seen = 0;
        done = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            step(c);
            if (c == 1) done = 1'b0;
            if (done_lvl !== 1'b0) glitch_seen++;
        end
        check_eq("done_glitch", 32'(glitch_seen), 0);
        first_hi = -1;
        done = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            step(c);
            if (done_lvl === 1'b1 && first_hi < 0) first_hi = c;
        end
        check_eq("done_rise_cycle", 32'(first_hi), 4);
        check_eq("done_stays_high", 32'(done_lvl), 1);
        check_eq("done_no_pulse", 32'(sub_q.size() + del_q.size() + rb_q.size()), 0);

        check_eq("pulses_exclusive", 32'(n_multi), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
